// File: rtl/delay_line_ctrl.sv
// Sample-gated delay line sequencer for an external simple-dual-port BRAM.
// Delay is counted in accepted samples; length is reprogrammable at runtime.
module delay_line_ctrl #(
    parameter int DATA_WIDTH  = 25,
    parameter int ADDR_WIDTH  = 9,
    parameter int DEFAULT_LEN = 511
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  cfg_load,
    input  logic [ADDR_WIDTH-1:0] cfg_len,
    output logic                  cfg_err,
    input  logic                  di_valid,
    input  logic [DATA_WIDTH-1:0] di,
    output logic                  do_valid,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  primed,
    output logic                  ram_wren,
    output logic [ADDR_WIDTH-1:0] ram_wraddr,
    output logic [DATA_WIDTH-1:0] ram_di,
    output logic                  ram_rden,
    output logic [ADDR_WIDTH-1:0] ram_rdaddr,
    input  logic [DATA_WIDTH-1:0] ram_do
);

    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] len;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] fill_cnt;
    logic [ADDR_WIDTH-1:0] fill_next;
    logic                  rd_pend;
    logic                  accepted;
    logic                  load_ok;

    assign accepted  = di_valid & en & (state != IDLE);
    assign load_ok   = cfg_load & (cfg_len != '0);
    assign fill_next = fill_cnt + 1'b1;

    // Addresses are gated so the RAM port sees zeros whenever nothing is issued.
    assign ram_wren   = accepted;
    assign ram_rden   = accepted;
    assign ram_wraddr = accepted ? wr_ptr : '0;
    assign ram_rdaddr = accepted ? wr_ptr - len : '0;
    assign ram_di     = di;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            len      <= ADDR_WIDTH'(DEFAULT_LEN);
            wr_ptr   <= '0;
            fill_cnt <= '0;
            rd_pend  <= 1'b0;
            do_valid <= 1'b0;
            data_o   <= '0;
            primed   <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            cfg_err <= cfg_load & (cfg_len == '0);
            // A successful load kills both the read issued now and the one in flight.
            rd_pend  <= accepted & (state == RUN) & ~load_ok;
            do_valid <= rd_pend & ~load_ok;
            if (rd_pend && !load_ok)
                data_o <= ram_do;
            if (accepted)
                wr_ptr <= wr_ptr + 1'b1;
            if (load_ok)
                len <= cfg_len;

            if (!en) begin
                state    <= IDLE;
                primed   <= 1'b0;
                fill_cnt <= '0;
            end else if (load_ok && state != IDLE) begin
                // A sample arriving with the load is k=0 of the new fill.
                fill_cnt <= accepted ? ADDR_WIDTH'(1) : '0;
                if (accepted && cfg_len == ADDR_WIDTH'(1)) begin
                    state  <= RUN;
                    primed <= 1'b1;
                end else begin
                    state  <= FILL;
                    primed <= 1'b0;
                end
            end else begin
                case (state)
                    IDLE: state <= FILL;
                    FILL: if (accepted) begin
                        fill_cnt <= fill_next;
                        if (fill_next == len) begin
                            state  <= RUN;
                            primed <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Directed bench for delay_line_ctrl with a behavioural BRAM (1-cycle read latency).
module tb_delay_line_ctrl;

    localparam int DW = 25;
    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          rst_n, en, cfg_load, cfg_err, di_valid, do_valid, primed;
    logic [AW-1:0] cfg_len, ram_wraddr, ram_rdaddr;
    logic [DW-1:0] di, data_o, ram_di, ram_do;
    logic          ram_wren, ram_rden;

    int checks = 0;
    int errors = 0;

    delay_line_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEFAULT_LEN(511)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .cfg_load(cfg_load), .cfg_len(cfg_len),
        .cfg_err(cfg_err), .di_valid(di_valid), .di(di), .do_valid(do_valid),
        .data_o(data_o), .primed(primed), .ram_wren(ram_wren), .ram_wraddr(ram_wraddr),
        .ram_di(ram_di), .ram_rden(ram_rden), .ram_rdaddr(ram_rdaddr), .ram_do(ram_do)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [1 << AW];
    always @(posedge clk) begin
        if (ram_wren) mem[ram_wraddr] <= ram_di;
        if (ram_rden) ram_do <= mem[ram_rdaddr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drives a stream of incrementing samples; outputs must be consecutive from
    // 'first', and all but 'lag' accepted samples must produce exactly one output.
    task automatic run_stream(input int n, input bit rnd, input int base, input int first,
                              input int lag);
        int val, exp, acc, outs;
        val = base; exp = first; acc = 0; outs = 0;
        for (int i = 0; i < n + 3; i++) begin
            en       = 1'b1;
            cfg_load = 1'b0;
            di_valid = (i < n) && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
            di       = di_valid ? DW'(val) : DW'($urandom);
            @(posedge clk); #1;
            if (di_valid) begin val++; acc++; end
            if (do_valid) begin
                chk("stream_data", 32'(data_o), 32'(exp));
                exp++;
                outs++;
            end
        end
        chk("stream_count", 32'(outs), 32'(acc - lag));
    endtask

    typedef struct {
        bit            en, load;
        logic [AW-1:0] len;
        bit            dv;
        logic [DW-1:0] di;
        bit            x_wren;
        logic [AW-1:0] x_wraddr, x_rdaddr;
        bit            x_dv;
        logic [DW-1:0] x_data;
        bit            x_primed;
    } vec_t;

    vec_t tbl [12];

    initial begin
        // len=4 fill and steady state, including two stall cycles
        tbl[0]  = '{1, 1, 4, 0, 0, 0, 0,   0, 0, 0, 0};
        tbl[1]  = '{1, 0, 0, 1, 0, 1, 0, 508, 0, 0, 0};
        tbl[2]  = '{1, 0, 0, 1, 1, 1, 1, 509, 0, 0, 0};
        tbl[3]  = '{1, 0, 0, 1, 2, 1, 2, 510, 0, 0, 0};
        tbl[4]  = '{1, 0, 0, 1, 3, 1, 3, 511, 0, 0, 1};
        tbl[5]  = '{1, 0, 0, 1, 4, 1, 4,   0, 0, 0, 1};
        tbl[6]  = '{1, 0, 0, 1, 5, 1, 5,   1, 1, 0, 1};
        tbl[7]  = '{1, 0, 0, 1, 6, 1, 6,   2, 1, 1, 1};
        tbl[8]  = '{1, 0, 0, 0, 0, 0, 0,   0, 1, 2, 1};
        tbl[9]  = '{1, 0, 0, 0, 0, 0, 0,   0, 0, 2, 1};
        tbl[10] = '{1, 0, 0, 1, 7, 1, 7,   3, 0, 2, 1};
        tbl[11] = '{1, 0, 0, 0, 0, 0, 0,   0, 1, 3, 1};

        rst_n = 1'b0; en = 1'b1; cfg_load = 1'b0; cfg_len = '0; di_valid = 1'b1; di = 25'd77;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_do_valid", 32'(do_valid), 0);
        chk("rst_data_o", 32'(data_o), 0);
        chk("rst_primed", 32'(primed), 0);
        chk("rst_cfg_err", 32'(cfg_err), 0);
        chk("rst_wren", 32'(ram_wren), 0);
        chk("rst_rden", 32'(ram_rden), 0);
        chk("rst_wraddr", 32'(ram_wraddr), 0);
        chk("rst_rdaddr", 32'(ram_rdaddr), 0);
        rst_n = 1'b1; en = 1'b0; di_valid = 1'b0;
        @(posedge clk); #1;

        // Test 1: table-driven len=4
        for (int i = 0; i < 12; i++) begin
            en = tbl[i].en; cfg_load = tbl[i].load; cfg_len = tbl[i].len;
            di_valid = tbl[i].dv; di = tbl[i].di;
            #1;
            chk("t1_wren", 32'(ram_wren), 32'(tbl[i].x_wren));
            chk("t1_rden", 32'(ram_rden), 32'(tbl[i].x_wren));
            chk("t1_wraddr", 32'(ram_wraddr), 32'(tbl[i].x_wraddr));
            chk("t1_rdaddr", 32'(ram_rdaddr), 32'(tbl[i].x_rdaddr));
            @(posedge clk); #1;
            chk("t1_do_valid", 32'(do_valid), 32'(tbl[i].x_dv));
            chk("t1_data_o", 32'(data_o), 32'(tbl[i].x_data));
            chk("t1_primed", 32'(primed), 32'(tbl[i].x_primed));
        end
        cfg_load = 1'b0;

        // Test 2: random stalls, stream continues from di=8, outputs from 4
        run_stream(80, 1'b1, 8, 4, 0);

        // Test 3: fresh reset, default len=511, 2000 continuous samples
        rst_n = 1'b0; di_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; en = 1'b1;
        @(posedge clk); #1;
        run_stream(2000, 1'b0, 0, 0, 511);

        // Test 4: reload len=8 from RUN, then load len=3 with a sample mid-stream
        en = 1'b1; cfg_load = 1'b1; cfg_len = 9'd8; di_valid = 1'b0;
        @(posedge clk); #1;
        run_stream(12, 1'b0, 2000, 2000, 8);
        for (int i = 0; i < 10; i++) begin
            en = 1'b1; di_valid = 1'b1; di = DW'(3000 + i);
            cfg_load = (i == 3); cfg_len = (i == 3) ? 9'd3 : 9'd0;
            @(posedge clk); #1;
            if (i >= 3) begin
                chk("t4_do_valid", 32'(do_valid), 32'(i >= 7));
                chk("t4_primed", 32'(primed), 32'(i >= 5));
                if (i >= 7) chk("t4_data_o", 32'(data_o), 32'(3003 + i - 7));
            end
        end

        // Test 5: cfg_len=0 is rejected, stream undisturbed
        for (int i = 0; i < 8; i++) begin
            en = 1'b1; di_valid = 1'b1; di = DW'(4000 + i);
            cfg_load = (i == 2); cfg_len = 9'd0;
            @(posedge clk); #1;
            chk("t5_cfg_err", 32'(cfg_err), 32'(i == 2));
            chk("t5_do_valid", 32'(do_valid), 1);
            chk("t5_primed", 32'(primed), 1);
            if (i >= 4) chk("t5_data_o", 32'(data_o), 32'(4000 + i - 4));
        end
        cfg_load = 1'b0;

        // Test 6: one-cycle reset mid-RUN drops pending output, forces refill
        rst_n = 1'b0; di_valid = 1'b1; di = 25'd4100;
        @(posedge clk); #1;
        chk("t6_do_valid", 32'(do_valid), 0);
        chk("t6_data_o", 32'(data_o), 0);
        chk("t6_primed", 32'(primed), 0);
        chk("t6_cfg_err", 32'(cfg_err), 0);
        rst_n = 1'b1; di = 25'd123;
        #1;
        chk("t6_idle_wren", 32'(ram_wren), 0);
        chk("t6_idle_rden", 32'(ram_rden), 0);
        chk("t6_idle_wraddr", 32'(ram_wraddr), 0);
        chk("t6_idle_rdaddr", 32'(ram_rdaddr), 0);
        @(posedge clk); #1;
        chk("t6_pending_dropped", 32'(do_valid), 0);
        run_stream(516, 1'b0, 5000, 5000, 511);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
